// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared constants and state encoding for the life line scheduler
package life_pkg;

  localparam int CELLS     = 640;
  localparam int ADDR_W    = 10;
  localparam int CELL_W    = 4;
  localparam int ALIVE_BIT = 3;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    EV_PRIME,
    EV_READ,
    EV_WRITE
  } state_t;

endpackage

// File: rtl/life_rule.sv
// rtl/life_rule.sv - elementary cellular automaton rule applied to one cell
module life_rule
  import life_pkg::*;
#(
  parameter logic [7:0] RULE        = 8'd30,
  parameter logic [2:0] ALIVE_COLOR = 3'b010
) (
  input  logic              l_alive,
  input  logic [CELL_W-1:0] c,
  input  logic              r_alive,
  output logic [CELL_W-1:0] new_cell
);

  logic [2:0] pattern;
  logic       alive;

  assign pattern = {l_alive, c[ALIVE_BIT], r_alive};
  assign alive   = RULE[pattern];

  // A surviving cell keeps its colour; a newborn gets the fixed birth colour.
  assign new_cell = alive ? {1'b1, (c[ALIVE_BIT] ? c[ALIVE_BIT-1:0] : ALIVE_COLOR)} : '0;

endmodule

// File: rtl/life_mem_scheduler.sv
// rtl/life_mem_scheduler.sv - shares the cell RAM between display, reseed and evolve
module life_mem_scheduler
  import life_pkg::*;
#(
  parameter logic [7:0] RULE        = 8'd30,
  parameter logic [2:0] ALIVE_COLOR = 3'b010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              display_active,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              frame_tick,
  input  logic              reseed_req,
  input  logic [CELL_W-1:0] random,
  input  logic [7:0]        gen_div,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [CELL_W-1:0] mem_wdata,
  input  logic [CELL_W-1:0] mem_rdata,
  output logic              busy,
  output logic [15:0]       generation
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic              l_q, l_nx;
  logic [CELL_W-1:0] c_q, c_nx;
  logic [7:0]        cnt;
  logic              evolve_pend, seed_pend, ev_set;
  logic              rd_valid_q;
  logic [CELL_W-1:0] rdat_q, rdat, r_cell, new_cell;
  logic [ADDR_W-1:0] int_addr;
  logic              int_we;
  logic [CELL_W-1:0] int_wdata;
  logic              rd_issue, clr_seed, clr_evolve, seed_done, ev_done;

  // Read data lands one cycle after issue; hold it across display stalls.
  assign rdat   = rd_valid_q ? mem_rdata : rdat_q;
  assign r_cell = (idx == LAST) ? '0 : rdat;
  assign ev_set = frame_tick && (gen_div != 8'd0) && (cnt >= gen_div - 8'd1);

  assign mem_addr  = display_active ? disp_addr : int_addr;
  assign mem_we    = int_we;
  assign mem_wdata = int_wdata;
  assign busy      = (state != IDLE);

  life_rule #(.RULE(RULE), .ALIVE_COLOR(ALIVE_COLOR)) u_rule (
    .l_alive  (l_q),
    .c        (c_q),
    .r_alive  (r_cell[ALIVE_BIT]),
    .new_cell (new_cell)
  );

  // Next-state and RAM access decode; everything freezes while the display owns the RAM.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    l_nx       = l_q;
    c_nx       = c_q;
    int_addr   = '0;
    int_we     = 1'b0;
    int_wdata  = '0;
    rd_issue   = 1'b0;
    clr_seed   = 1'b0;
    clr_evolve = 1'b0;
    seed_done  = 1'b0;
    ev_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (seed_pend) begin
          state_nx   = SEED;
          clr_seed   = 1'b1;
          clr_evolve = 1'b1;
        end else if (evolve_pend) begin
          state_nx = EV_PRIME;
        end
      end
      SEED: begin
        int_addr  = idx;
        int_we    = 1'b1;
        int_wdata = random;
        idx_nx    = idx + 1'b1;
        if (idx == LAST) begin
          idx_nx    = '0;
          seed_done = 1'b1;
          state_nx  = IDLE;
        end
      end
      EV_PRIME: begin
        clr_evolve = 1'b1;
        rd_issue   = 1'b1;
        l_nx       = 1'b0;
        idx_nx     = '0;
        state_nx   = EV_READ;
      end
      EV_READ: begin
        if (idx == '0) c_nx = rdat;
        if (idx != LAST) begin
          int_addr = idx + 1'b1;
          rd_issue = 1'b1;
        end else begin
          int_addr = idx;
        end
        state_nx = EV_WRITE;
      end
      EV_WRITE: begin
        int_addr  = idx;
        int_we    = 1'b1;
        int_wdata = new_cell;
        l_nx      = c_q[ALIVE_BIT];
        c_nx      = r_cell;
        idx_nx    = idx + 1'b1;
        state_nx  = EV_READ;
        if (idx == LAST) begin
          idx_nx   = '0;
          ev_done  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (display_active) begin
      state_nx   = state;
      idx_nx     = idx;
      l_nx       = l_q;
      c_nx       = c_q;
      int_we     = 1'b0;
      rd_issue   = 1'b0;
      clr_seed   = 1'b0;
      clr_evolve = 1'b0;
      seed_done  = 1'b0;
      ev_done    = 1'b0;
    end
  end

  // FSM state, cell index, neighbour window and read-capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      l_q        <= 1'b0;
      c_q        <= '0;
      rd_valid_q <= 1'b0;
      rdat_q     <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      l_q        <= l_nx;
      c_q        <= c_nx;
      rd_valid_q <= rd_issue;
      if (rd_valid_q) rdat_q <= mem_rdata;
    end
  end

  // Pending requests, frame divider and generation count; a new request beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= 8'd0;
      evolve_pend <= 1'b0;
      seed_pend   <= 1'b1;
      generation  <= 16'd0;
    end else begin
      seed_pend   <= reseed_req | (seed_pend & ~clr_seed);
      evolve_pend <= ev_set | (evolve_pend & ~clr_evolve);
      if (seed_done || gen_div == 8'd0) cnt <= 8'd0;
      else if (frame_tick)              cnt <= ev_set ? 8'd0 : cnt + 8'd1;
      if (seed_done)    generation <= 16'd0;
      else if (ev_done) generation <= generation + 16'd1;
    end
  end

endmodule

// File: tb/tb_life_mem_scheduler.sv
// tb/tb_life_mem_scheduler.sv - randomized self-checking bench for life_mem_scheduler
module tb_life_mem_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       display_active = 1'b0;
  logic [9:0] disp_addr = '0;
  logic       frame_tick = 1'b0;
  logic       reseed_req = 1'b0;
  logic [3:0] random = 4'hA;
  logic [7:0] gen_div = 8'd0;

  logic [9:0]  mem_addr   [2];
  logic        mem_we     [2];
  logic [3:0]  mem_wdata  [2];
  logic [3:0]  mem_rdata  [2];
  logic        busy       [2];
  logic [15:0] generation [2];

  logic [3:0] ram   [2][640];
  logic [3:0] model [2][640];
  logic [3:0] bd_pat [640];
  logic       bd_load = 1'b0;
  int         gen_model = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  life_mem_scheduler #(.RULE(8'd30), .ALIVE_COLOR(3'b010)) dut (
    .clk(clk), .rst(rst), .display_active(display_active), .disp_addr(disp_addr),
    .frame_tick(frame_tick), .reseed_req(reseed_req), .random(random), .gen_div(gen_div),
    .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .generation(generation[0])
  );

  life_mem_scheduler #(.RULE(8'hFE), .ALIVE_COLOR(3'b010)) dut_fe (
    .clk(clk), .rst(rst), .display_active(display_active), .disp_addr(disp_addr),
    .frame_tick(frame_tick), .reseed_req(reseed_req), .random(random), .gen_div(gen_div),
    .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .generation(generation[1])
  );

  // Single-port cell RAMs with one-cycle read latency, plus a backdoor preload.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (bd_load) begin
        for (int a = 0; a < 640; a++) ram[k][a] <= bd_pat[a];
      end else if (mem_we[k] && mem_addr[k] < 10'd640) begin
        ram[k][mem_addr[k]] <= mem_wdata[k];
      end
      mem_rdata[k] <= (mem_addr[k] < 10'd640) ? ram[k][mem_addr[k]] : 4'h0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // While the display owns the RAM the scheduler must not write and must pass the address through.
  always @(negedge clk) begin
    if (rst && display_active) begin
      for (int k = 0; k < 2; k++) begin
        check("we_while_display", 32'(mem_we[k]), 32'd0);
        check("addr_passthru", 32'(mem_addr[k]), 32'(disp_addr));
      end
    end
  end

  task automatic evolve_model(input int k, input logic [7:0] rule);
    logic [3:0] old [640];
    for (int a = 0; a < 640; a++) old[a] = model[k][a];
    for (int a = 0; a < 640; a++) begin
      int l, c, r, p;
      l = (a > 0)   ? int'(old[a-1][3]) : 0;
      c = int'(old[a][3]);
      r = (a < 639) ? int'(old[a+1][3]) : 0;
      p = 4 * l + 2 * c + r;
      if (rule[p]) model[k][a] = (c != 0) ? old[a] : 4'b1010;
      else         model[k][a] = 4'b0000;
    end
  endtask

  task automatic evolve_both();
    evolve_model(0, 8'd30);
    evolve_model(1, 8'hFE);
    gen_model = (gen_model + 1) % 65536;
  endtask

  task automatic seed_model(input logic [3:0] v);
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 640; a++) model[k][a] = v;
    gen_model = 0;
  endtask

  task automatic compare_ram(input string tag);
    for (int k = 0; k < 2; k++) begin
      int bad = 0;
      for (int a = 0; a < 640; a++) if (ram[k][a] !== model[k][a]) bad++;
      check($sformatf("%s_ram%0d", tag, k), 32'(bad), 32'd0);
      check($sformatf("%s_gen%0d", tag, k), 32'(generation[k]), 32'(gen_model));
    end
  endtask

  task automatic load_pattern();
    bd_load = 1'b1;
    @(posedge clk); #1;
    bd_load = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 640; a++) model[k][a] = bd_pat[a];
  endtask

  task automatic random_pattern();
    for (int a = 0; a < 640; a++) bd_pat[a] = 4'($urandom);
    load_pattern();
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic pulse_reseed();
    reseed_req = 1'b1;
    @(posedge clk); #1;
    reseed_req = 1'b0;
  endtask

  // Runs until the current operation ends (busy falls); mode 0 quiet, 1 display every 8 cycles, 2 random display.
  task automatic run_op(input string tag, input int mode, input int budget, output int n);
    bit seen = 0;
    n = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      display_active = (mode == 1) ? ((c / 8) % 2 == 1) :
                       (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      disp_addr = 10'($urandom_range(0, 1023));
      @(negedge clk);
      if (busy[0]) begin
        seen = 1;
        n++;
      end else if (seen) begin
        break;
      end
    end
    display_active = 1'b0;
    check($sformatf("%s_done", tag), 32'(seen && !busy[0]), 32'd1);
  endtask

  task automatic quiet_tick(input string tag);
    pulse_tick();
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check(tag, 32'(busy[0]), 32'd0);
  endtask

  initial begin
    int n;
    int fr;
    logic [3:0] rv;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_we", 32'(mem_we[k]), 32'd0);
      check("rst_addr", 32'(mem_addr[k]), 32'd0);
      check("rst_wdata", 32'(mem_wdata[k]), 32'd0);
      check("rst_busy", 32'(busy[k]), 32'd0);
      check("rst_gen", 32'(generation[k]), 32'd0);
    end

    @(posedge clk); #1;
    rst = 1'b1;
    run_op("seed_a", 0, 3000, n);
    check("seed_a_cycles", 32'(n), 32'd640);
    seed_model(4'hA);
    compare_ram("seed_a");

    for (int a = 0; a < 640; a++) bd_pat[a] = 4'h0;
    bd_pat[320] = 4'b1001;
    load_pattern();
    gen_div = 8'd1;
    pulse_tick();
    run_op("ev1", 0, 3000, n);
    check("ev1_cycles", 32'(n >= 1279 && n <= 1283), 32'd1);
    evolve_both();
    compare_ram("ev1");
    check("ev1_c318", 32'(ram[0][318]), 32'h0);
    check("ev1_c319", 32'(ram[0][319]), 32'hA);
    check("ev1_c320", 32'(ram[0][320]), 32'h9);
    check("ev1_c321", 32'(ram[0][321]), 32'hA);
    check("ev1_c322", 32'(ram[0][322]), 32'h0);

    load_pattern();
    pulse_tick();
    run_op("ev_stall", 1, 6000, n);
    evolve_both();
    compare_ram("ev_stall");
    check("ev_stall_c319", 32'(ram[0][319]), 32'hA);

    gen_div = 8'd0;
    rv = 4'($urandom);
    random = rv;
    pulse_reseed();
    run_op("seed_r", 2, 6000, n);
    seed_model(rv);
    compare_ram("seed_r");

    gen_div = 8'd3;
    fr = 0;
    for (int t = 0; t < 7; t++) begin
      random_pattern();
      fr = (fr + 1) % 3;
      if (fr == 0) begin
        pulse_tick();
        run_op("ev_div3", 2, 6000, n);
        evolve_both();
        compare_ram("ev_div3");
      end else begin
        quiet_tick("div3_no_evolve");
      end
    end
    check("div3_count", 32'(generation[0]), 32'd2);

    gen_div = 8'd0;
    for (int t = 0; t < 5; t++) quiet_tick("div0_no_evolve");
    check("div0_count", 32'(generation[0]), 32'd2);

    random_pattern();
    gen_div = 8'd1;
    pulse_tick();
    repeat (202) begin @(posedge clk); #1; end
    check("busy_mid_evolve", 32'(busy[0]), 32'd1);
    rv = 4'($urandom);
    random = rv;
    pulse_reseed();
    gen_div = 8'd0;
    run_op("ev_then_seed", 0, 3000, n);
    evolve_both();
    compare_ram("ev_then_seed");
    run_op("seed_after_ev", 0, 3000, n);
    check("seed_after_ev_cycles", 32'(n), 32'd640);
    seed_model(rv);
    compare_ram("seed_after_ev");

    for (int a = 0; a < 640; a++) bd_pat[a] = 4'h0;
    bd_pat[0]   = 4'b1001;
    bd_pat[639] = 4'b1100;
    load_pattern();
    gen_div = 8'd1;
    pulse_tick();
    run_op("edge", 0, 3000, n);
    gen_div = 8'd0;
    evolve_both();
    compare_ram("edge");
    check("edge30_c0", 32'(ram[0][0]), 32'h9);
    check("edge30_c1", 32'(ram[0][1]), 32'hA);
    check("edge30_c638", 32'(ram[0][638]), 32'hA);
    check("edge30_c639", 32'(ram[0][639]), 32'hC);
    check("edgefe_c1", 32'(ram[1][1]), 32'hA);
    check("edgefe_c2", 32'(ram[1][2]), 32'h0);
    check("edgefe_c637", 32'(ram[1][637]), 32'h0);
    check("edgefe_c638", 32'(ram[1][638]), 32'hA);

    random = 4'h5;
    pulse_reseed();
    repeat (100) begin @(posedge clk); #1; end
    check("busy_mid_seed", 32'(busy[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("midrst_we", 32'(mem_we[k]), 32'd0);
      check("midrst_busy", 32'(busy[k]), 32'd0);
      check("midrst_gen", 32'(generation[k]), 32'd0);
      check("midrst_addr", 32'(mem_addr[k]), 32'd0);
      check("midrst_wdata", 32'(mem_wdata[k]), 32'd0);
    end
    @(posedge clk); #1;
    rv = 4'($urandom);
    random = rv;
    rst = 1'b1;
    run_op("seed_after_rst", 0, 3000, n);
    check("seed_after_rst_cycles", 32'(n), 32'd640);
    seed_model(rv);
    compare_ram("seed_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
